ldst_sequencer: RTL

LDST_SEQUENCER -- requirements
Module: ldst_sequencer

---
 rtl/ldst_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ldst_sequencer.sv
// Load/store/load-immediate control sequencer: IDLE plus T0..T7 microsteps driving 17 datapath strobes.
// Define LDST_SEQUENCER_TRACE_EN to add the 16-bit retired-instruction counter port instr_cnt.
module ldst_sequencer #(
  parameter int               OPC_W   = 5,
  parameter int               MEM_LAT = 1,
  parameter logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000),
  parameter logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'b00001),
  parameter logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010),
  parameter logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [OPC_W-1:0] ir_opc,
  output logic [16:0]      ctrl,
  output logic [OPC_W-1:0] alu_op,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal
`ifdef LDST_SEQUENCER_TRACE_EN
  ,
  output logic [15:0]      instr_cnt
`endif
);

  localparam int C_PCOUT   = 0;
  localparam int C_INCPC   = 1;
  localparam int C_MARIN   = 2;
  localparam int C_READ    = 3;
  localparam int C_WRITE   = 4;
  localparam int C_MDRIN   = 5;
  localparam int C_MDROUT  = 6;
  localparam int C_IRIN    = 7;
  localparam int C_GRA     = 8;
  localparam int C_GRB     = 9;
  localparam int C_RIN     = 10;
  localparam int C_ROUT    = 11;
  localparam int C_BAOUT   = 12;
  localparam int C_YIN     = 13;
  localparam int C_COUT    = 14;
  localparam int C_ZIN     = 15;
  localparam int C_ZLOWOUT = 16;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_wait;
  logic [OPC_W-1:0]   r_opc;
  logic               r_illegal;
  logic [16:0]        w_ctrl;
  logic [OPC_W-1:0]   w_alu_op;
  logic               w_done;
  logic               w_set_illegal;
  logic               w_opc_legal;
  state_t             w_end_state;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= S_IDLE;
      r_wait    <= 4'd0;
      r_opc     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T3) r_opc <= ir_opc;
      if (w_set_illegal) r_illegal <= 1'b1;
      // Every entry into a memory-wait state reloads; otherwise count down to zero and hold.
      if (w_next != r_state) begin
        r_wait <= (w_next == S_T1 || w_next == S_T6 || w_next == S_T7) ? LAT_M1 : 4'd0;
      end else if (r_wait != 4'd0) begin
        r_wait <= r_wait - 4'd1;
      end
    end
  end

  assign w_opc_legal = (ir_opc == OP_LD) || (ir_opc == OP_LDI) || (ir_opc == OP_ST);
  assign w_end_state = run ? S_T0 : S_IDLE;

  always_comb begin
    w_next        = r_state;
    w_ctrl        = 17'd0;
    w_alu_op      = '0;
    w_done        = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run && !r_illegal) w_next = S_T0;
      end
      S_T0: begin
        w_ctrl[C_PCOUT] = 1'b1;
        w_ctrl[C_MARIN] = 1'b1;
        w_ctrl[C_INCPC] = 1'b1;
        w_next          = S_T1;
      end
      S_T1: begin
        w_ctrl[C_READ]  = 1'b1;
        w_ctrl[C_MDRIN] = 1'b1;
        if (r_wait == 4'd0) w_next = S_T2;
      end
      S_T2: begin
        w_ctrl[C_MDROUT] = 1'b1;
        w_ctrl[C_IRIN]   = 1'b1;
        w_next           = S_T3;
      end
      S_T3: begin
        w_ctrl[C_GRB]   = 1'b1;
        w_ctrl[C_BAOUT] = 1'b1;
        w_ctrl[C_YIN]   = 1'b1;
        if (w_opc_legal) begin
          w_next = S_T4;
        end else begin
          w_set_illegal = 1'b1;
          w_next        = S_IDLE;
        end
      end
      S_T4: begin
        w_ctrl[C_COUT] = 1'b1;
        w_ctrl[C_ZIN]  = 1'b1;
        w_alu_op       = OP_ADD;
        w_next         = S_T5;
      end
      S_T5: begin
        w_ctrl[C_ZLOWOUT] = 1'b1;
        if (r_opc == OP_LDI) begin
          w_ctrl[C_GRA] = 1'b1;
          w_ctrl[C_RIN] = 1'b1;
          w_done        = 1'b1;
          w_next        = w_end_state;
        end else begin
          w_ctrl[C_MARIN] = 1'b1;
          w_next          = S_T6;
        end
      end
      S_T6: begin
        if (r_opc == OP_LD) begin
          w_ctrl[C_READ]  = 1'b1;
          w_ctrl[C_MDRIN] = 1'b1;
          if (r_wait == 4'd0) w_next = S_T7;
        end else begin
          w_ctrl[C_GRA]   = 1'b1;
          w_ctrl[C_ROUT]  = 1'b1;
          w_ctrl[C_MDRIN] = 1'b1;
          w_next          = S_T7;
        end
      end
      S_T7: begin
        w_ctrl[C_MDROUT] = 1'b1;
        if (r_opc == OP_LD) begin
          w_ctrl[C_GRA] = 1'b1;
          w_ctrl[C_RIN] = 1'b1;
          w_done        = 1'b1;
          w_next        = w_end_state;
        end else begin
          w_ctrl[C_WRITE] = 1'b1;
          if (r_wait == 4'd0) begin
            w_done = 1'b1;
            w_next = w_end_state;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from reset-cleared registers, so clr drops every strobe at once.
  assign ctrl       = w_ctrl;
  assign alu_op     = w_alu_op;
  assign state      = r_state;
  assign instr_done = w_done;
  assign illegal    = r_illegal;

`ifdef LDST_SEQUENCER_TRACE_EN
  logic [15:0] r_instr_cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_instr_cnt <= 16'd0;
    end else if (w_done) begin
      r_instr_cnt <= r_instr_cnt + 16'd1;
    end
  end

  assign instr_cnt = r_instr_cnt;
`endif

endmodule
